// File: rtl/axi_lite_reg_responder.sv
// -----------------------------------------------------------------------------
// axi_lite_reg_responder
// AXI4-Lite slave with 28 read/write 32-bit registers at word addresses 0-27,
// reserved words 28-30 (SLVERR) and a read-only identification word at 31.
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   awaddr/awcache/awprot         write address (cache/prot ignored)
//   awvalid/awready               write address handshake
//   wdata/wstrb, wvalid/wready    write data, byte enables, handshake
//   bresp, bvalid/bready          write response
//   araddr/arcache/arprot         read address (cache/prot ignored)
//   arvalid/arready               read address handshake
//   rdata/rresp, rvalid/rready    read data channel
//
// The write path latches AW and W independently in holding registers; the
// write commits on the edge where both are held and stays parked (readies low)
// until the response is taken. The read path is a single outstanding read.
// -----------------------------------------------------------------------------
module axi_lite_reg_responder #(
    parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [4:0]  awaddr,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [4:0]  araddr,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);

    localparam int          NREG   = 28;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    // Merge new data into an old word under byte enables.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0] regs_q [NREG];
    logic [31:0] regs_d [NREG];

    logic        aw_full_q, aw_full_d;
    logic [4:0]  aw_addr_q, aw_addr_d;
    logic        w_full_q,  w_full_d;
    logic [31:0] w_data_q,  w_data_d;
    logic [3:0]  w_strb_q,  w_strb_d;
    logic        awready_q, awready_d;
    logic        wready_q,  wready_d;
    logic        bvalid_q,  bvalid_d;
    logic [1:0]  bresp_q,   bresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q,  rvalid_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [1:0]  rresp_q,   rresp_d;

    logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic unused_s;

    assign unused_s = ^{awcache, awprot, arcache, arprot};

    assign aw_hs_s = awvalid & awready_q;
    assign w_hs_s  = wvalid  & wready_q;
    assign b_hs_s  = bvalid_q & bready;
    assign ar_hs_s = arvalid & arready_q;
    assign r_hs_s  = rvalid_q & rready;

    // Write path: holding registers, commit, and response.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end

        if (b_hs_s) begin
            // Response taken: release both holding registers together.
            bvalid_d  = 1'b0;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end else begin
            if (aw_hs_s) begin
                aw_full_d = 1'b1;
                aw_addr_d = awaddr;
            end else begin
                aw_full_d = aw_full_q;
            end
            if (w_hs_s) begin
                w_full_d = 1'b1;
                w_data_d = wdata;
                w_strb_d = wstrb;
            end else begin
                w_full_d = w_full_q;
            end
        end

        // Commit uses the post-handshake view so a same-edge completion counts.
        if (aw_full_d && w_full_d && !bvalid_q) begin
            bvalid_d = 1'b1;
            if (aw_addr_d < 5'd28) begin
                bresp_d = OKAY;
                for (int i = 0; i < NREG; i++) begin
                    if (aw_addr_d == 5'(i)) begin
                        regs_d[i] = strb_merge(regs_q[i], w_data_d, w_strb_d);
                    end else begin
                        regs_d[i] = regs_q[i];
                    end
                end
            end else begin
                bresp_d = SLVERR;
            end
        end else begin
            bvalid_d = bvalid_d;
        end

        awready_d = !aw_full_d && !bvalid_d;
        wready_d  = !w_full_d  && !bvalid_d;
    end

    // Read path: one outstanding read, data taken from pre-write register state.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            if (araddr < 5'd28) begin
                rresp_d = OKAY;
                rdata_d = 32'h0000_0000;
                for (int i = 0; i < NREG; i++) begin
                    if (araddr == 5'(i)) begin
                        rdata_d = regs_q[i];
                    end else begin
                        rdata_d = rdata_d;
                    end
                end
            end else if (araddr == 5'd31) begin
                rresp_d = OKAY;
                rdata_d = ID_VALUE;
            end else begin
                rresp_d = SLVERR;
                rdata_d = 32'h0000_0000;
            end
        end else if (r_hs_s) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
        arready_d = !rvalid_d;
    end

    // State registers; reset abandons any in-flight transaction.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
            aw_full_q <= 1'b0;
            aw_addr_q <= 5'd0;
            w_full_q  <= 1'b0;
            w_data_q  <= 32'h0000_0000;
            w_strb_q  <= 4'h0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0000_0000;
            rresp_q   <= 2'b00;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// -----------------------------------------------------------------------------
// Bench for axi_lite_reg_responder: directed AXI-Lite transactions, a
// transaction-level reference model checked against every output each cycle,
// and literal expectations at the points of interest.
// -----------------------------------------------------------------------------
module tb_axi_lite_reg_responder;

    localparam logic [31:0] ID = 32'hA11E_0001;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [4:0]  awaddr;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_assert = 0;
    int n_fail   = 0;

    axi_lite_reg_responder dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] mem [0:27];
    bit          pend_aw, pend_w;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_strb;
    bit          m_awready, m_wready, m_arready, m_bvalid, m_rvalid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;

    task automatic model_clear();
        for (int i = 0; i < 28; i++) mem[i] = 32'h0;
        pend_aw = 1'b0; pend_w = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_bvalid = 1'b0; m_rvalid = 1'b0;
        m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'h0;
    endtask

    initial begin
        model_clear();
        forever begin
            bit hs_aw, hs_w, hs_ar, hs_b, hs_r;
            @(posedge aclk or negedge aresetn);
            if (!aresetn) begin
                model_clear();
            end else begin
                hs_aw = awvalid && m_awready;
                hs_w  = wvalid  && m_wready;
                hs_ar = arvalid && m_arready;
                hs_b  = m_bvalid && bready;
                hs_r  = m_rvalid && rready;
                // read sees memory as it was before this edge
                if (hs_ar) begin
                    m_rvalid = 1'b1;
                    if (araddr <= 5'd27) begin m_rdata = mem[araddr]; m_rresp = 2'b00; end
                    else if (araddr == 5'd31) begin m_rdata = ID; m_rresp = 2'b00; end
                    else begin m_rdata = 32'h0; m_rresp = 2'b10; end
                end else if (hs_r) begin
                    m_rvalid = 1'b0;
                end
                if (hs_b) begin m_bvalid = 1'b0; pend_aw = 1'b0; pend_w = 1'b0; end
                if (hs_aw) begin pend_aw = 1'b1; p_addr = awaddr; end
                if (hs_w)  begin pend_w = 1'b1; p_data = wdata; p_strb = wstrb; end
                if (pend_aw && pend_w && !m_bvalid) begin
                    m_bvalid = 1'b1;
                    if (p_addr <= 5'd27) begin
                        m_bresp = 2'b00;
                        for (int i = 0; i < 4; i++)
                            if (p_strb[i]) mem[p_addr][8*i +: 8] = p_data[8*i +: 8];
                    end else begin
                        m_bresp = 2'b10;
                    end
                end
                m_awready = !pend_aw && !m_bvalid;
                m_wready  = !pend_w  && !m_bvalid;
                m_arready = !m_rvalid;
            end
        end
    end

    // every-cycle comparison of all outputs against the model
    initial begin
        forever begin
            @(negedge aclk);
            chk("awready", {31'h0, awready}, {31'h0, m_awready});
            chk("wready",  {31'h0, wready},  {31'h0, m_wready});
            chk("arready", {31'h0, arready}, {31'h0, m_arready});
            chk("bvalid",  {31'h0, bvalid},  {31'h0, m_bvalid});
            chk("bresp",   {30'h0, bresp},   {30'h0, m_bresp});
            chk("rvalid",  {31'h0, rvalid},  {31'h0, m_rvalid});
            chk("rdata",   rdata, m_rdata);
            chk("rresp",   {30'h0, rresp},   {30'h0, m_rresp});
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] exp_resp, input int aw_dly, input int w_dly,
                      input int b_hold);
        bit aw_done = 1'b0, w_done = 1'b0, a_now, w_now;
        int n = 0;
        @(negedge aclk);
        bready = (b_hold == 0);
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && n < 30) begin
            awvalid = !aw_done && (n >= aw_dly);
            wvalid  = !w_done  && (n >= w_dly);
            a_now = awvalid && awready;
            w_now = wvalid && wready;
            @(negedge aclk);
            n++;
            if (a_now) aw_done = 1'b1;
            if (w_now) w_done = 1'b1;
            if (w_done && !aw_done) chk("wready_low_after_w", {31'h0, wready}, 32'h0);
            if (aw_done && !w_done) chk("awready_low_after_aw", {31'h0, awready}, 32'h0);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("write_handshake_timeout", {31'h0, aw_done && w_done}, 32'h1);
        chk("bvalid_1cyc_after_hs", {31'h0, bvalid}, 32'h1);
        chk("bresp_value", {30'h0, bresp}, {30'h0, exp_resp});
        for (int i = 0; i < b_hold; i++) begin
            @(negedge aclk);
            chk("bvalid_held", {31'h0, bvalid}, 32'h1);
            chk("bresp_stable", {30'h0, bresp}, {30'h0, exp_resp});
            chk("awready_blocked", {31'h0, awready}, 32'h0);
            chk("wready_blocked", {31'h0, wready}, 32'h0);
        end
        bready = 1'b1;
        @(negedge aclk);
        chk("bvalid_cleared", {31'h0, bvalid}, 32'h0);
        chk("awready_after_b", {31'h0, awready}, 32'h1);
        chk("wready_after_b", {31'h0, wready}, 32'h1);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
        bit done = 1'b0, now;
        int n = 0;
        @(negedge aclk);
        araddr = a; arvalid = 1'b1;
        while (!done && n < 30) begin
            now = arready;
            @(negedge aclk);
            n++;
            if (now) done = 1'b1;
        end
        arvalid = 1'b0;
        chk("read_handshake_timeout", {31'h0, done}, 32'h1);
        chk("rvalid_1cyc_after_ar", {31'h0, rvalid}, 32'h1);
        chk("rdata_value", rdata, exp_d);
        chk("rresp_value", {30'h0, rresp}, {30'h0, exp_r});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        awaddr = 5'd0; awcache = 4'h0; awprot = 3'h0; awvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b1;
        araddr = 5'd0; arcache = 4'h0; arprot = 3'h0; arvalid = 1'b0; rready = 1'b1;

        repeat (2) @(negedge aclk);
        chk("reset_awready", {31'h0, awready}, 32'h0);
        chk("reset_arready", {31'h0, arready}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("release_awready", {31'h0, awready}, 32'h1);
        chk("release_wready", {31'h0, wready}, 32'h1);
        chk("release_arready", {31'h0, arready}, 32'h1);

        // same-edge AW/W then readback
        wr(5'd5, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 0);
        rd(5'd5, 32'hDEADBEEF, 2'b00);

        // W three cycles ahead of AW, partial strobes
        wr(5'd2, 32'h12345678, 4'b0101, 2'b00, 3, 0, 0);
        rd(5'd2, 32'h00340078, 2'b00);

        // AW ahead of W
        wr(5'd27, 32'hCAFEF00D, 4'hF, 2'b00, 0, 2, 0);
        rd(5'd27, 32'hCAFEF00D, 2'b00);

        // error addresses
        wr(5'd31, 32'hFFFFFFFF, 4'hF, 2'b10, 0, 0, 0);
        wr(5'd29, 32'hFFFFFFFF, 4'hF, 2'b10, 0, 0, 0);
        rd(5'd31, ID, 2'b00);
        rd(5'd29, 32'h0, 2'b10);
        rd(5'd28, 32'h0, 2'b10);

        // zero strobes: OKAY, no change
        wr(5'd4, 32'hFFFFFFFF, 4'h0, 2'b00, 0, 0, 0);
        rd(5'd4, 32'h0, 2'b00);

        // response back-pressure
        wr(5'd9, 32'h55AA55AA, 4'hF, 2'b00, 0, 0, 5);
        rd(5'd9, 32'h55AA55AA, 2'b00);

        // read and write commit on the same edge to the same address
        wr(5'd7, 32'h1, 4'hF, 2'b00, 0, 0, 0);
        fork
            wr(5'd7, 32'h2, 4'hF, 2'b00, 0, 0, 0);
            rd(5'd7, 32'h1, 2'b00);
        join
        rd(5'd7, 32'h2, 2'b00);

        // reset between AW and W handshakes
        @(negedge aclk);
        awaddr = 5'd3; awvalid = 1'b1; wdata = 32'hABCD1234; wstrb = 4'hF;
        @(negedge aclk);
        awvalid = 1'b0;
        #1 aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        chk("midreset_awready", {31'h0, awready}, 32'h0);
        chk("midreset_bvalid", {31'h0, bvalid}, 32'h0);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("post_reset_awready", {31'h0, awready}, 32'h1);
        chk("post_reset_wready", {31'h0, wready}, 32'h1);
        chk("post_reset_arready", {31'h0, arready}, 32'h1);
        chk("post_reset_bvalid", {31'h0, bvalid}, 32'h0);
        for (int a = 0; a < 28; a++) begin
            rd(5'(a), 32'h0, 2'b00);
        end

        repeat (2) @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_responder.md
AXI_LITE_REG_RESPONDER -- requirements
Module: axi_lite_reg_responder

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'hA11E_0001, the read-only value returned at word address 31.
REQ-002 SHALL have one clock and reset: asynchronous, active-low reset; ports listed below, clock and reset first.
REQ-003 aclk  input  1  sole clock; all state changes on its rising edge.
REQ-004 aresetn  input  1  asynchronous active-low reset.
REQ-005 awaddr  input  5  write word address.
REQ-006 awcache, awprot  input  4, 3  accepted and ignored.
REQ-007 awvalid / awready  input / output  1 / 1  write-address handshake.
REQ-008 wdata, wstrb  input  32, 4  write data; byte enables, where wstrb[i] gates wdata[8i+7:8i].
REQ-009 wvalid / wready  input / output  1 / 1  write-data handshake.
REQ-010 bresp, bvalid / bready  output, output / input  2, 1 / 1  write response.
REQ-011 araddr  input  5  read word address; arcache (4) and arprot (3) are inputs, ignored.
REQ-012 arvalid / arready  input / output  1 / 1  read-address handshake.
REQ-013 rdata, rresp, rvalid / rready  output, output, output / input  32, 2, 1 / 1  read data channel.

Function
REQ-014 SHALL hold 28 RW 32-bit registers at word addresses 0-27; addresses 28-30 are reserved; address 31 is read-only and returns ID_VALUE.
REQ-015 A handshake SHALL occur on a rising edge where valid and ready are both 1.
REQ-016 awready SHALL be 1 only when the AW holding register is empty and bvalid=0; wready SHALL be 1 only when the W holding register is empty and bvalid=0.
REQ-017 AW and W SHALL be accepted in either order or on the same edge; each SHALL be captured independently and SHALL drop its ready on the edge after capture.
REQ-018 On the edge where both AW and W are held (including the edge completing the second handshake), the responder SHALL commit the write per wstrb and set bvalid; bvalid SHALL therefore appear 1 cycle after the last handshake.
REQ-019 bresp SHALL be 2'b00 (OKAY) for addresses 0-27 and 2'b10 (SLVERR) for addresses 28-31; SLVERR writes SHALL leave all state unchanged.
REQ-020 wstrb=4'b0000 SHALL return OKAY with no register change.
REQ-021 bvalid and bresp SHALL stay stable until the bready handshake; that edge SHALL clear bvalid and both holding registers, and awready/wready SHALL be 1 on the following cycle.
REQ-022 arready SHALL equal !rvalid (registered state); one read SHALL be outstanding at most.
REQ-023 On an AR handshake, rdata/rresp SHALL be registered and rvalid set, visible 1 cycle later; they SHALL stay stable until the rready handshake, which clears rvalid.
REQ-024 Reads of addresses 0-27 SHALL return the register with OKAY; address 31 SHALL return ID_VALUE with OKAY; addresses 28-30 SHALL return rdata=0 with SLVERR.
REQ-025 If an AR handshake and a write commit to the same address share an edge, rdata SHALL be the pre-write value.
REQ-026 Read and write paths SHALL be fully independent; neither SHALL stall the other.
REQ-027 Output bvalid=1 with bready held at 1 SHALL permit back-to-back writes every 2 cycles; rvalid=1 with rready held at 1 SHALL permit back-to-back reads every 2 cycles.

Reset
REQ-028 While aresetn=0: all registers SHALL be 0; awready, wready, arready, bvalid and rvalid SHALL be 0; bresp, rresp and rdata SHALL be 0; holding registers SHALL be empty.
REQ-029 awready, wready and arready SHALL become 1 on the first rising edge with aresetn=1.
REQ-030 Reset asserted mid-transaction SHALL abandon it immediately with no partial register update visible afterwards.

Verification
REQ-031 Write addr 5, data 32'hDEADBEEF, wstrb 4'hF, AW and W on the same edge -> bvalid one cycle later with bresp=00; a subsequent read of addr 5 -> rdata=32'hDEADBEEF, rresp=00.
REQ-032 W presented 3 cycles before AW (addr 2, data 32'h12345678, wstrb 4'b0101) starting from 0 -> wready drops after W; bvalid one cycle after the AW handshake; read of addr 2 -> 32'h00340078.
REQ-033 Write addr 31 and addr 29 -> bresp=10 each; read addr 31 -> ID_VALUE with OKAY; read addr 29 -> rdata=0, rresp=10.
REQ-034 Hold bready=0 for 5 cycles after bvalid -> bresp stable, awready=wready=0 throughout; a new AW is not accepted until 1 cycle after bready.
REQ-035 Addr 7 holds 32'h1, write 32'h2 commits on the same edge as an AR to addr 7 -> rdata=32'h1; the next read of addr 7 -> 32'h2.
REQ-036 Assert aresetn=0 after the AW handshake but before W, then release -> no bvalid; reads of every address 0-27 return 0; readies are 1 one edge after release.
